cache_axi_bridge: RTL



---
 rtl/cache_axi_bridge.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_axi_bridge.sv
// Data-cache to AXI master bridge: line refills and dirty-line write-backs as
// 4x32-bit INCR bursts, single beats for byte/half/word, one read and one write in flight.
module cache_axi_bridge #(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} w_state_e;

    localparam logic [2:0] TYPE_LINE  = 3'b100;
    localparam logic [1:0] BURST_INCR = 2'b01;

    function automatic logic [7:0] axi_len(input logic [2:0] t);
        return (t == TYPE_LINE) ? 8'd3 : 8'd0;
    endfunction

    function automatic logic [2:0] axi_size(input logic [2:0] t);
        return (t == TYPE_LINE) ? 3'd2 : {1'b0, t[1:0]};
    endfunction

    r_state_e       r_state_q, r_state_d;
    logic [31:0]    rd_addr_q, rd_addr_d;
    logic [2:0]     rd_type_q, rd_type_d;

    w_state_e       w_state_q, w_state_d;
    logic [31:0]    wr_addr_q, wr_addr_d;
    logic [2:0]     wr_type_q, wr_type_d;
    logic [127:0]   wr_data_q, wr_data_d;
    logic [3:0]     wr_strb_q, wr_strb_d;
    logic [1:0]     cnt_q, cnt_d;

    logic           raw_block_s;
    logic           wlast_s;
    logic [31:0]    wdata_s;
    logic           unused_s;

    assign unused_s = ^{rid, rresp, bid, bresp};

    // Read-after-write hazard: also compare against a write being accepted this very cycle
    always_comb begin
        if (w_state_q != W_IDLE) begin
            raw_block_s = (rd_addr[31:4] == wr_addr_q[31:4]);
        end else begin
            raw_block_s = wr_req & (rd_addr[31:4] == wr_addr[31:4]);
        end
    end

    assign rd_rdy    = (r_state_q == R_IDLE) & ~raw_block_s;
    assign arid      = RD_ID;
    assign araddr    = rd_addr_q;
    assign arlen     = axi_len(rd_type_q);
    assign arsize    = axi_size(rd_type_q);
    assign arburst   = BURST_INCR;
    assign arvalid   = (r_state_q == R_AR);
    assign rready    = (r_state_q == R_DATA);
    assign ret_valid = (r_state_q == R_DATA) & rvalid;
    assign ret_last  = (r_state_q == R_DATA) & rlast;
    assign ret_data  = rdata;

    // Read FSM next state and request latch
    always_comb begin
        r_state_d = r_state_q;
        rd_addr_d = rd_addr_q;
        rd_type_d = rd_type_q;
        case (r_state_q)
            R_IDLE: begin
                if (rd_req && rd_rdy) begin
                    rd_addr_d = rd_addr;
                    rd_type_d = rd_type;
                    r_state_d = R_AR;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_AR: begin
                if (arready) begin
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_AR;
                end
            end
            R_DATA: begin
                if (rvalid && rlast) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            rd_addr_q <= 32'd0;
            rd_type_q <= 3'd0;
        end else begin
            r_state_q <= r_state_d;
            rd_addr_q <= rd_addr_d;
            rd_type_q <= rd_type_d;
        end
    end

    assign wlast_s = (cnt_q == ((wr_type_q == TYPE_LINE) ? 2'd3 : 2'd0));

    // Select the current write beat from the latched line
    always_comb begin
        case (cnt_q)
            2'd0:    wdata_s = wr_data_q[31:0];
            2'd1:    wdata_s = wr_data_q[63:32];
            2'd2:    wdata_s = wr_data_q[95:64];
            2'd3:    wdata_s = wr_data_q[127:96];
            default: wdata_s = 32'd0;
        endcase
    end

    assign wr_rdy  = (w_state_q == W_IDLE);
    assign awid    = WR_ID;
    assign awaddr  = wr_addr_q;
    assign awlen   = axi_len(wr_type_q);
    assign awsize  = axi_size(wr_type_q);
    assign awburst = BURST_INCR;
    assign awvalid = (w_state_q == W_AW);
    assign wid     = WR_ID;
    assign wdata   = wdata_s;
    assign wstrb   = (wr_type_q == TYPE_LINE) ? 4'hF : wr_strb_q;
    assign wlast   = wlast_s;
    assign wvalid  = (w_state_q == W_DATA);
    assign bready  = (w_state_q == W_RESP);

    // Write FSM next state, request latch and beat counter
    always_comb begin
        w_state_d = w_state_q;
        wr_addr_d = wr_addr_q;
        wr_type_d = wr_type_q;
        wr_data_d = wr_data_q;
        wr_strb_d = wr_strb_q;
        cnt_d     = cnt_q;
        case (w_state_q)
            W_IDLE: begin
                if (wr_req) begin
                    wr_addr_d = wr_addr;
                    wr_type_d = wr_type;
                    wr_data_d = wr_data;
                    wr_strb_d = wr_wstrb;
                    cnt_d     = 2'd0;
                    w_state_d = W_AW;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_AW: begin
                if (awready) begin
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_AW;
                end
            end
            W_DATA: begin
                if (wready) begin
                    cnt_d     = cnt_q + 2'd1;
                    w_state_d = wlast_s ? W_RESP : W_DATA;
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            wr_addr_q <= 32'd0;
            wr_type_q <= 3'd0;
            wr_data_q <= 128'd0;
            wr_strb_q <= 4'd0;
            cnt_q     <= 2'd0;
        end else begin
            w_state_q <= w_state_d;
            wr_addr_q <= wr_addr_d;
            wr_type_q <= wr_type_d;
            wr_data_q <= wr_data_d;
            wr_strb_q <= wr_strb_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
